// File: rtl/slave_port_pkg.sv
// Shared types and default sizes for the serial slave port and its serializer.
package slave_port_pkg;

    localparam int DEF_ADDR_WIDTH = 12;
    localparam int DEF_DATA_WIDTH = 8;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        WDATA,
        MEMWR,
        MEMRD,
        RWAIT,
        RSEND
    } state_e;

    // One spare bit so the counter can represent the full width without wrapping.
    function automatic int cnt_width(input int a_w, input int d_w);
        return $clog2((a_w > d_w) ? a_w : d_w) + 1;
    endfunction

endpackage

// File: rtl/slave_piso.sv
// Parallel-in serial-out shifter for read data: loads a word, then emits it LSB first
// with valid held for exactly DATA_WIDTH cycles.
module slave_piso
    import slave_port_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  load_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic                  sdata_o,
    output logic                  valid_o
);

    localparam int REM_W = $clog2(DATA_WIDTH + 1);

    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [REM_W-1:0]      rem_q, rem_d;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            shift_q <= '0;
            rem_q   <= '0;
        end else begin
            shift_q <= shift_d;
            rem_q   <= rem_d;
        end
    end

    always_comb begin
        shift_d = shift_q;
        rem_d   = rem_q;
        if (load_i) begin
            shift_d = data_i;
            rem_d   = REM_W'(DATA_WIDTH);
        end else if (rem_q != '0) begin
            shift_d = shift_q >> 1;
            rem_d   = rem_q - 1'b1;
        end
    end

    assign valid_o = (rem_q != '0);
    // Line is forced low outside the valid window so idle bus reads as zero.
    assign sdata_o = valid_o & shift_q[0];

endmodule

// File: rtl/slave_port.sv
// Bit-serial bus slave: receives address (and write data) LSB first, performs one memory
// access, and for reads returns the word serially. ADDR_WIDTH must be at least 2.
module slave_port
    import slave_port_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  swdata,
    input  logic                  smode,
    input  logic                  mvalid,
    output logic                  srdata,
    output logic                  svalid,
    output logic                  sready,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_wen,
    output logic                  mem_ren,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_rvalid
);

    localparam int CNT_W = cnt_width(ADDR_WIDTH, DATA_WIDTH);

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  mode_q, mode_d;

    logic                  addr_cap, data_cap;
    logic [CNT_W-1:0]      addr_idx;
    logic                  piso_load;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            mode_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            mode_q  <= mode_d;
        end
    end

    // Address bit 0 arrives with the start cycle, so ADDR writes bit cnt+1.
    assign addr_cap = mvalid && ((state_q == IDLE) || (state_q == ADDR));
    assign data_cap = mvalid && (state_q == WDATA);
    assign addr_idx = (state_q == IDLE) ? '0 : cnt_q + 1'b1;

    generate
        for (genvar gi = 0; gi < ADDR_WIDTH; gi++) begin : g_addr_bit
            assign addr_d[gi] = (addr_cap && (addr_idx == CNT_W'(gi))) ? swdata : addr_q[gi];
        end
        for (genvar gi = 0; gi < DATA_WIDTH; gi++) begin : g_data_bit
            assign wdata_d[gi] = (data_cap && (cnt_q == CNT_W'(gi))) ? swdata : wdata_q[gi];
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        case (state_q)
            IDLE: begin
                if (mvalid) begin
                    mode_d  = smode;
                    state_d = ADDR;
                end
            end
            ADDR: begin
                if (mvalid && (cnt_q == CNT_W'(ADDR_WIDTH - 2))) begin
                    state_d = mode_q ? WDATA : MEMRD;
                end
            end
            WDATA: begin
                if (mvalid && (cnt_q == CNT_W'(DATA_WIDTH - 1))) begin
                    state_d = MEMWR;
                end
            end
            MEMWR:   state_d = IDLE;
            MEMRD:   state_d = RWAIT;
            RWAIT: begin
                if (mem_rvalid) begin
                    state_d = RSEND;
                end
            end
            RSEND: begin
                if (cnt_q == CNT_W'(DATA_WIDTH - 1)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (addr_cap || data_cap || (state_q == RSEND)) begin
            cnt_d = cnt_q + 1'b1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    always_comb begin
        sready    = (state_q == IDLE);
        mem_wen   = (state_q == MEMWR);
        mem_ren   = (state_q == MEMRD);
        piso_load = (state_q == RWAIT) && mem_rvalid;
    end

    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

    slave_piso #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_piso (
        .clk     (clk),
        .rstn    (rstn),
        .load_i  (piso_load),
        .data_i  (mem_rdata),
        .sdata_o (srdata),
        .valid_o (svalid)
    );

endmodule

// File: tb/tb_slave_port.sv
// Directed bench for slave_port with a small behavioural memory answering reads after two cycles.
module tb_slave_port;

    logic        clk = 1'b0;
    logic        rstn;
    logic        swdata, smode, mvalid;
    logic        srdata, svalid, sready;
    logic [11:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_wen, mem_ren;
    logic [7:0]  mem_rdata;
    logic        mem_rvalid;

    logic [7:0]  mem [0:4095];
    logic [11:0] rd_addr = '0;
    logic        ren_d1 = 1'b0, ren_d2 = 1'b0;
    logic        spur_rv;

    int n_checks = 0;
    int n_fail   = 0;
    int wen_count = 0, ren_count = 0, sv_count = 0, sr_bad = 0;

    always #5 clk = ~clk;

    slave_port dut (
        .clk        (clk),
        .rstn       (rstn),
        .swdata     (swdata),
        .smode      (smode),
        .mvalid     (mvalid),
        .srdata     (srdata),
        .svalid     (svalid),
        .sready     (sready),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_wen    (mem_wen),
        .mem_ren    (mem_ren),
        .mem_rdata  (mem_rdata),
        .mem_rvalid (mem_rvalid)
    );

    always @(posedge clk) begin
        if (mem_wen) mem[mem_addr] = mem_wdata;
        if (mem_ren) rd_addr = mem_addr;
        ren_d2 <= ren_d1;
        ren_d1 <= mem_ren;
    end
    assign mem_rdata  = mem[rd_addr];
    assign mem_rvalid = ren_d2 | spur_rv;

    always @(negedge clk) begin
        if (mem_wen) wen_count++;
        if (mem_ren) ren_count++;
        if (svalid) sv_count++;
        if (!svalid && srdata) sr_bad++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bits(input logic mode, input logic [19:0] bits, input int n,
                             input int gap_at, input int gap_len);
        for (int i = 0; i < n; i++) begin
            if (i == gap_at) begin
                mvalid = 1'b0;
                repeat (gap_len) begin
                    tick();
                    check("gap_sready", sready, 0);
                    check("gap_wen", mem_wen, 0);
                end
            end
            mvalid = 1'b1;
            swdata = bits[i];
            smode  = (i == 0) ? mode : 1'($urandom_range(0, 1));
            tick();
            if (i == 0) check("sready_drop", sready, 0);
        end
        mvalid = 1'b0;
        swdata = 1'b0;
    endtask

    task automatic do_write(input logic [11:0] a, input logic [7:0] d, input int gap_at, input int gap_len);
        int w0;
        w0 = wen_count;
        check("wr_sready_start", sready, 1);
        send_bits(1'b1, {d, a}, 20, gap_at, gap_len);
        check("wr_wen", mem_wen, 1);
        check("wr_addr", mem_addr, a);
        check("wr_wdata", mem_wdata, d);
        check("wr_sready_busy", sready, 0);
        tick();
        check("wr_wen_drop", mem_wen, 0);
        check("wr_sready_back", sready, 1);
        check("wr_wen_pulses", wen_count - w0, 1);
        $display("write addr=%h data=%h", a, d);
    endtask

    task automatic do_read(input logic [11:0] a, input logic [7:0] exp, input logic mv_in_send);
        logic [7:0] got;
        got = '0;
        send_bits(1'b0, {8'h00, a}, 12, -1, 0);
        check("rd_ren", mem_ren, 1);
        check("rd_addr", mem_addr, a);
        tick();
        check("rd_ren_drop", mem_ren, 0);
        check("rd_svalid_wait1", svalid, 0);
        tick();
        check("rd_svalid_wait2", svalid, 0);
        tick();
        for (int i = 0; i < 8; i++) begin
            check("rd_svalid", svalid, 1);
            check("rd_bit", srdata, exp[i]);
            got[i] = srdata;
            if (mv_in_send) begin
                mvalid = 1'b1;
                swdata = 1'b1;
            end
            tick();
        end
        mvalid = 1'b0;
        swdata = 1'b0;
        check("rd_svalid_end", svalid, 0);
        check("rd_sready_end", sready, 1);
        check("rd_word", got, exp);
        $display("read  addr=%h data=%h", a, got);
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
        mem[12'h0FF] = 8'h3D;
        rstn = 1'b0; swdata = 1'b0; smode = 1'b0; mvalid = 1'b0; spur_rv = 1'b0;
        #12;
        check("rst_sready", sready, 1);
        check("rst_svalid", svalid, 0);
        check("rst_srdata", srdata, 0);
        check("rst_wen", mem_wen, 0);
        check("rst_ren", mem_ren, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_wdata", mem_wdata, 0);
        tick();
        rstn = 1'b1;
        tick();

        do_write(12'h5A3, 8'hC6, -1, 0);
        do_read(12'h0FF, 8'h3D, 1'b0);
        do_write(12'h001, 8'h80, 6, 3);

        // Abort a write after five address bits.
        begin
            int w0;
            w0 = wen_count;
            for (int i = 0; i < 5; i++) begin
                mvalid = 1'b1; swdata = 1'b1; smode = 1'b1;
                tick();
            end
            #2 rstn = 1'b0;
            mvalid = 1'b0;
            #1;
            check("abort_sready", sready, 1);
            check("abort_addr", mem_addr, 0);
            check("abort_wdata", mem_wdata, 0);
            check("abort_wen", mem_wen, 0);
            tick();
            rstn = 1'b1;
            tick();
            check("abort_no_write", wen_count - w0, 0);
            $display("reset pulse after 5 address bits");
        end
        do_write(12'hFFF, 8'hFF, -1, 0);

        spur_rv = 1'b1;
        tick();
        spur_rv = 1'b0;
        check("spur_sready", sready, 1);
        check("spur_svalid", svalid, 0);
        tick();
        check("spur_sready2", sready, 1);
        $display("spurious mem_rvalid in idle");
        do_read(12'h0FF, 8'h3D, 1'b1);

        do_write(12'h7FF, 8'h11, -1, 0);
        do_read(12'h7FF, 8'h11, 1'b0);

        repeat (3) tick();
        check("mem_5a3", mem[12'h5A3], 8'hC6);
        check("mem_001", mem[12'h001], 8'h80);
        check("mem_fff", mem[12'hFFF], 8'hFF);
        check("total_wen", wen_count, 4);
        check("total_ren", ren_count, 3);
        check("total_svalid", sv_count, 24);
        check("srdata_idle_zero", sr_bad, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
